// File: rtl/lut_cfg_pkg.sv
// Shared state encoding and sizing helpers for the LUT configuration loader.
// The ERR state exists only when LUT_CFG_PARITY_EN is defined.
package lut_cfg_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_SET  = 3'd2,
        S_HOLD = 3'd3,
        S_DONE = 3'd4
`ifdef LUT_CFG_PARITY_EN
        , S_ERR = 3'd5
`endif
    } state_t;

    // Stream words needed to fill one LUT image.
    function automatic int unsigned calc_words(input int unsigned mem_size,
                                               input int unsigned cfg_width);
        return mem_size / cfg_width;
    endfunction

    // Index register width; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lut_cfg_assembler.sv
// Assembles one LUT image from CONFIG_WIDTH-bit stream words, first word in the LSBs.
module lut_cfg_assembler
    import lut_cfg_pkg::*;
#(
    parameter int unsigned MEM_SIZE     = 16,
    parameter int unsigned CONFIG_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_clear,
    input  logic                    i_wr_en,
    input  logic [CONFIG_WIDTH-1:0] i_data,
    output logic [MEM_SIZE-1:0]     o_image,
    output logic                    o_last_word_c
);

    localparam int unsigned WORDS  = calc_words(MEM_SIZE, CONFIG_WIDTH);
    localparam int unsigned WIDX_W = idx_width(WORDS);
    localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(WORDS - 1);

    logic [MEM_SIZE-1:0] r_image;
    logic [WIDX_W-1:0]   r_word_idx;

    // Word pointer: wraps after the last word so the next image starts at word 0.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_word_idx <= '0;
        end else if (i_wr_en) begin
            r_word_idx <= (r_word_idx == LAST_IDX) ? '0 : r_word_idx + WIDX_W'(1);
        end
    end

    for (genvar g = 0; g < WORDS; g++) begin : g_word
        always_ff @(posedge clk) begin
            if (reset || i_clear) begin
                r_image[g*CONFIG_WIDTH +: CONFIG_WIDTH] <= '0;
            end else if (i_wr_en && (r_word_idx == WIDX_W'(g))) begin
                r_image[g*CONFIG_WIDTH +: CONFIG_WIDTH] <= i_data;
            end
        end
    end

    assign o_image       = r_image;
    assign o_last_word_c = (r_word_idx == LAST_IDX);

endmodule

// File: rtl/lut_config_loader.sv
// Streams truth tables into NUM_LUTS LUTs, strobing one comb_set bit per completed image.
// Define LUT_CFG_PARITY_EN to check even parity per word and stop in a sticky ERR state.
module lut_config_loader
    import lut_cfg_pkg::*;
#(
    parameter int unsigned INPUTS       = 4,
    parameter int unsigned MEM_SIZE     = 2**INPUTS,
    parameter int unsigned CONFIG_WIDTH = 8,
    parameter int unsigned NUM_LUTS     = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cfg_start,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [CONFIG_WIDTH-1:0] cfg_data,
    input  logic                    cfg_parity,
    output logic [MEM_SIZE-1:0]     config_in,
    output logic [NUM_LUTS-1:0]     comb_set,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    if ((MEM_SIZE % CONFIG_WIDTH) != 0) begin : g_bad_width
        $error("lut_config_loader: MEM_SIZE must be a multiple of CONFIG_WIDTH");
    end

    localparam int unsigned LIDX_W = idx_width(NUM_LUTS);
    localparam logic [LIDX_W-1:0] LAST_LUT = LIDX_W'(NUM_LUTS - 1);

    state_t              r_state;
    logic [LIDX_W-1:0]   r_lut_idx;
    logic                r_cfg_ready;
    logic [NUM_LUTS-1:0] r_comb_set;
    logic                r_busy;
    logic                r_done;
    logic                w_accept;
    logic                w_wr_en;
    logic                w_clear;
    logic                w_last_word;
    logic                w_last_lut;
    logic [MEM_SIZE-1:0] w_image;

    assign w_accept   = cfg_valid && r_cfg_ready;
    assign w_last_lut = (r_lut_idx == LAST_LUT);

`ifdef LUT_CFG_PARITY_EN
    logic r_err;
    logic w_parity_bad;

    assign w_parity_bad = ^{cfg_data, cfg_parity};
    assign w_wr_en      = w_accept && !w_parity_bad;
    assign err          = r_err;
`else
    logic w_unused_parity;

    assign w_unused_parity = cfg_parity;
    assign w_wr_en         = w_accept;
    assign err             = 1'b0;
`endif

    // Image restarts from zero at every load start and before each following LUT.
    always_comb begin
        w_clear = 1'b0;
        case (r_state)
            S_IDLE:  w_clear = cfg_start;
`ifdef LUT_CFG_PARITY_EN
            S_ERR:   w_clear = cfg_start;
`endif
            S_HOLD:  w_clear = !w_last_lut;
            default: w_clear = 1'b0;
        endcase
    end

    lut_cfg_assembler #(
        .MEM_SIZE     (MEM_SIZE),
        .CONFIG_WIDTH (CONFIG_WIDTH)
    ) u_assembler (
        .clk           (clk),
        .reset         (reset),
        .i_clear       (w_clear),
        .i_wr_en       (w_wr_en),
        .i_data        (cfg_data),
        .o_image       (w_image),
        .o_last_word_c (w_last_word)
    );

    // Sequencer; outputs are registered alongside the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_lut_idx   <= '0;
            r_cfg_ready <= 1'b0;
            r_comb_set  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef LUT_CFG_PARITY_EN
            r_err       <= 1'b0;
`endif
        end else begin
            r_comb_set <= '0;
            r_done     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cfg_start) begin
                        r_state     <= S_LOAD;
                        r_lut_idx   <= '0;
                        r_cfg_ready <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                S_LOAD: begin
`ifdef LUT_CFG_PARITY_EN
                    if (w_accept && w_parity_bad) begin
                        r_state     <= S_ERR;
                        r_cfg_ready <= 1'b0;
                        r_busy      <= 1'b0;
                        r_err       <= 1'b1;
                    end else
`endif
                    if (w_accept && w_last_word) begin
                        r_state     <= S_SET;
                        r_cfg_ready <= 1'b0;
                    end
                end
                S_SET: begin
                    r_comb_set <= NUM_LUTS'(1) << r_lut_idx;
                    r_state    <= S_HOLD;
                end
                S_HOLD: begin
                    if (w_last_lut) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state     <= S_LOAD;
                        r_lut_idx   <= r_lut_idx + LIDX_W'(1);
                        r_cfg_ready <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
`ifdef LUT_CFG_PARITY_EN
                S_ERR: begin
                    if (cfg_start) begin
                        r_state     <= S_LOAD;
                        r_lut_idx   <= '0;
                        r_cfg_ready <= 1'b1;
                        r_busy      <= 1'b1;
                        r_err       <= 1'b0;
                    end
                end
`endif
                default: begin
                    r_state     <= S_IDLE;
                    r_cfg_ready <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_ready = r_cfg_ready;
    assign config_in = w_image;
    assign comb_set  = r_comb_set;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_lut_config_loader.sv
// Scoreboard bench for lut_config_loader: driver predicts strobes/done, monitor checks them.
`timescale 1ns/1ps
module tb_lut_config_loader;

    localparam int unsigned INPUTS = 4;
    localparam int unsigned MEM    = 16;
    localparam int unsigned CW     = 8;
    localparam int unsigned NL     = 4;
    localparam int unsigned WORDS  = MEM / CW;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_start;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [CW-1:0] cfg_data;
    logic          cfg_parity;
    logic [MEM-1:0] config_in;
    logic [NL-1:0] comb_set;
    logic          busy;
    logic          done;
    logic          err;

    lut_config_loader #(
        .INPUTS       (INPUTS),
        .MEM_SIZE     (MEM),
        .CONFIG_WIDTH (CW),
        .NUM_LUTS     (NL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_start  (cfg_start),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_data   (cfg_data),
        .cfg_parity (cfg_parity),
        .config_in  (config_in),
        .comb_set   (comb_set),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [NL-1:0]  cs;
        logic [MEM-1:0] img;
        int             cyc;
    } strobe_t;

    strobe_t q_strobe[$];
    int      q_done[$];
    int      n_cmp  = 0;
    int      n_fail = 0;

    function automatic void chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: every strobe and done pulse must match the next predicted event.
    strobe_t e;
    bit      prev_strobe = 1'b0;
    always @(negedge clk) begin
        if (comb_set != '0) begin
            chk("strobe_onehot", $countones(comb_set), 1);
            chk("strobe_not_consecutive", prev_strobe, 0);
            if (q_strobe.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_strobe: got comb_set 0x%0h, expected none", comb_set);
            end else begin
                e = q_strobe.pop_front();
                chk("strobe_lut", comb_set, e.cs);
                chk("strobe_image", config_in, e.img);
                chk("strobe_cycle", cyc, e.cyc);
            end
        end
        prev_strobe = (comb_set != '0);
        if (done) begin
            if (q_done.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
            end else begin
                chk("done_cycle", cyc, q_done.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_cfg_ready"}, cfg_ready, 0);
        chk({tag, "_config_in"}, config_in, 0);
        chk({tag, "_comb_set"}, comb_set, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    // mode: 0 held valid 01..08, 1 five-cycle stall before word 1, 2 random stalls,
    //       3 cfg_start pulse in LUT 1, 4 reset in LUT 2, 5 bad parity on word 3
    task automatic do_load(input int mode);
        logic [CW-1:0]  w;
        logic [MEM-1:0] img;
        int             a;
        int             g;
        int             stall;
        g = 0;
        a = 0;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        chk("err_after_start", err, 0);
        for (int l = 0; l < NL; l++) begin
            img = '0;
            for (int k = 0; k < WORDS; k++) begin
                stall = 0;
                if (mode == 1 && g == 1) stall = 5;
                if (mode == 2 && $urandom_range(0, 2) == 0) stall = $urandom_range(1, 4);
                for (int s = 0; s < stall; s++) begin
                    cfg_valid  = 1'b0;
                    cfg_data   = CW'($urandom);
                    cfg_parity = 1'($urandom);
                    chk("ready_in_stall", cfg_ready, 1);
                    tick();
                end
                w = (mode == 0) ? CW'(g + 1) : CW'($urandom);
                cfg_valid  = 1'b1;
                cfg_data   = w;
                cfg_parity = ^w;
                if (mode == 5 && g == 3) cfg_parity = ~cfg_parity;
                cfg_start  = (mode == 3 && l == 1 && k == 0);
                chk("ready_in_load", cfg_ready, 1);
                chk("busy_in_load", busy, 1);
                a = cyc;
                tick();
                cfg_start = 1'b0;
                img = img | (MEM'(w) << (CW * k));
                g++;
                if (mode == 4 && l == 2) begin
                    cfg_valid = 1'b0;
                    reset = 1'b1;
                    tick();
                    reset = 1'b0;
                    check_all_zero("after_abort");
                    tick();
                    chk("idle_after_abort", busy, 0);
                    return;
                end
`ifdef LUT_CFG_PARITY_EN
                if (mode == 5 && g == 4) begin
                    chk("err_set", err, 1);
                    chk("err_ready", cfg_ready, 0);
                    chk("err_busy", busy, 0);
                    for (int s = 0; s < 5; s++) begin
                        cfg_valid  = 1'b1;
                        cfg_data   = CW'($urandom);
                        cfg_parity = ^cfg_data;
                        tick();
                        chk("err_sticky", err, 1);
                        chk("err_ready_low", cfg_ready, 0);
                    end
                    cfg_valid = 1'b0;
                    return;
                end
`endif
            end
            q_strobe.push_back('{cs: NL'(1) << l, img: img, cyc: a + 2});
            if (l == NL - 1) q_done.push_back(a + 3);
            cfg_valid = 1'($urandom);
            cfg_data  = CW'($urandom);
            chk("ready_in_set", cfg_ready, 0);
            tick();
            chk("ready_in_hold", cfg_ready, 0);
            chk("busy_in_hold", busy, 1);
            tick();
        end
        cfg_valid = 1'b0;
        chk("busy_in_done", busy, 1);
        chk("ready_in_done", cfg_ready, 0);
        tick();
        chk("idle_after_done", busy, 0);
        chk("err_clean", err, 0);
    endtask

    initial begin
        reset      = 1'b1;
        cfg_start  = 1'b0;
        cfg_valid  = 1'b0;
        cfg_data   = '0;
        cfg_parity = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();
        check_all_zero("idle");
        do_load(0);
        do_load(0);
        do_load(1);
        do_load(3);
        do_load(4);
        do_load(0);
`ifdef LUT_CFG_PARITY_EN
        do_load(5);
        do_load(0);
`endif
        repeat (20) do_load(2);
        repeat (4) tick();
        chk("strobe_queue_drained", q_strobe.size(), 0);
        chk("done_queue_drained", q_done.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout at cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule
